// File: rtl/destroyable_block_bank_if.sv
// Collision-report and block-state bus between the collision detector,
// the destroyable block bank and the renderer.
interface destroyable_block_bank_if #(
    parameter int NUM_BLOCKS = 8,
    parameter int COORD_W    = 10,
    parameter int HP_W       = 2
);
    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CNT_W = $clog2(NUM_BLOCKS + 1);
    localparam int SW    = 2 * COORD_W + 1;

    logic                     col_valid;
    logic [IDX_W-1:0]         col_idx;
    logic [HP_W-1:0]          col_dmg;
    logic [NUM_BLOCKS*SW-1:0] block_state;
    logic                     destroy_pulse;
    logic [IDX_W-1:0]         destroy_idx;
    logic [CNT_W-1:0]         alive_count;

    // Collision source / renderer side
    modport master (
        output col_valid, col_idx, col_dmg,
        input  block_state, destroy_pulse, destroy_idx, alive_count
    );

    // Block bank side
    modport slave (
        input  col_valid, col_idx, col_dmg,
        output block_state, destroy_pulse, destroy_idx, alive_count
    );
endinterface

// File: rtl/destroyable_block_bank.sv
// Bank of destroyable blocks: per-block hit points, post-hit invulnerability
// and timed respawn. Publishes packed {x, y, visible} per block, a one-cycle
// destroy event and the number of visible blocks. All outputs are registered.
module destroyable_block_bank #(
    parameter int NUM_BLOCKS    = 8,
    parameter int COORD_W       = 10,
    parameter int HP_W          = 2,
    parameter int INVULN_TICKS  = 4,
    parameter int RESPAWN_TICKS = 120
) (
    input  logic                                     sim_clk,
    input  logic                                     reset,
    input  logic                                     frame_tick,
    input  logic [NUM_BLOCKS*(2*COORD_W+HP_W)-1:0]   init_state,
    destroyable_block_bank_if.slave                  bus
);
    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CNT_W = $clog2(NUM_BLOCKS + 1);
    localparam int IW    = 2 * COORD_W + HP_W;
    localparam int SW    = 2 * COORD_W + 1;
    localparam int TMAX  = (INVULN_TICKS > RESPAWN_TICKS) ? INVULN_TICKS : RESPAWN_TICKS;
    localparam int TW    = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
    localparam logic [TW-1:0] INV_LD = TW'(INVULN_TICKS);
    localparam logic [TW-1:0] RSP_LD = TW'(RESPAWN_TICKS);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2,
        ST_GONE   = 2'd3
    } blk_st_e;

    // Per-block storage
    logic [COORD_W-1:0] home_x_q  [NUM_BLOCKS];
    logic [COORD_W-1:0] home_x_d  [NUM_BLOCKS];
    logic [COORD_W-1:0] home_y_q  [NUM_BLOCKS];
    logic [COORD_W-1:0] home_y_d  [NUM_BLOCKS];
    logic [HP_W-1:0]    init_hp_q [NUM_BLOCKS];
    logic [HP_W-1:0]    init_hp_d [NUM_BLOCKS];
    logic [HP_W-1:0]    hp_q      [NUM_BLOCKS];
    logic [HP_W-1:0]    hp_d      [NUM_BLOCKS];
    logic [TW-1:0]      tmr_q     [NUM_BLOCKS];
    logic [TW-1:0]      tmr_d     [NUM_BLOCKS];
    blk_st_e            st_q      [NUM_BLOCKS];
    blk_st_e            st_d      [NUM_BLOCKS];

    // Registered outputs
    logic [NUM_BLOCKS*SW-1:0] block_state_q, block_state_d;
    logic                     destroy_pulse_q, destroy_pulse_d;
    logic [IDX_W-1:0]         destroy_idx_q, destroy_idx_d;
    logic [CNT_W-1:0]         alive_count_q, alive_count_d;

    // HP after a hit, clamped at zero rather than wrapping
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        return (b >= a) ? '0 : (a - b);
    endfunction

    // Next-state for every block plus the output image derived from it
    always_comb begin
        logic             hit;
        logic [HP_W-1:0]  hp_new;
        logic [HP_W-1:0]  hp_init;
        logic             visible;

        home_x_d        = home_x_q;
        home_y_d        = home_y_q;
        init_hp_d       = init_hp_q;
        hp_d            = hp_q;
        tmr_d           = tmr_q;
        st_d            = st_q;
        block_state_d   = '0;
        destroy_pulse_d = 1'b0;
        destroy_idx_d   = '0;
        alive_count_d   = '0;
        hit             = 1'b0;
        hp_new          = '0;
        hp_init         = '0;
        visible         = 1'b0;

        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (reset) begin
                hp_init      = init_state[i*IW +: HP_W];
                home_x_d[i]  = init_state[i*IW + HP_W + COORD_W +: COORD_W];
                home_y_d[i]  = init_state[i*IW + HP_W +: COORD_W];
                init_hp_d[i] = hp_init;
                hp_d[i]      = hp_init;
                tmr_d[i]     = '0;
                st_d[i]      = (hp_init == '0) ? ST_GONE : ST_ALIVE;
            end else begin
                // Out-of-range indices never match any block
                hit = bus.col_valid && (bus.col_dmg != '0) &&
                      (bus.col_idx == IDX_W'(i));
                unique case (st_q[i])
                    ST_ALIVE: begin
                        if (hit) begin
                            hp_new  = sat_sub(hp_q[i], bus.col_dmg);
                            hp_d[i] = hp_new;
                            if (hp_new == '0) begin
                                st_d[i]         = (RESPAWN_TICKS == 0) ? ST_GONE : ST_DEAD;
                                tmr_d[i]        = RSP_LD;
                                destroy_pulse_d = 1'b1;
                                destroy_idx_d   = IDX_W'(i);
                            end else if (INVULN_TICKS != 0) begin
                                st_d[i]  = ST_INVULN;
                                tmr_d[i] = INV_LD;
                            end
                        end
                    end
                    ST_INVULN: begin
                        if (frame_tick) begin
                            tmr_d[i] = tmr_q[i] - TW'(1);
                            if (tmr_q[i] == TW'(1)) st_d[i] = ST_ALIVE;
                        end
                    end
                    ST_DEAD: begin
                        if (frame_tick) begin
                            tmr_d[i] = tmr_q[i] - TW'(1);
                            if (tmr_q[i] == TW'(1)) begin
                                st_d[i] = ST_ALIVE;
                                hp_d[i] = init_hp_q[i];
                            end
                        end
                    end
                    default: ;
                endcase
            end

            visible = (st_d[i] == ST_ALIVE) || (st_d[i] == ST_INVULN);
            block_state_d[i*SW +: SW] = visible ? {home_x_d[i], home_y_d[i], 1'b1} : '0;
            if (visible) alive_count_d = alive_count_d + CNT_W'(1);
        end
    end

    // State and output registers; reset is folded into the next-state logic
    always_ff @(posedge sim_clk) begin
        home_x_q        <= home_x_d;
        home_y_q        <= home_y_d;
        init_hp_q       <= init_hp_d;
        hp_q            <= hp_d;
        tmr_q           <= tmr_d;
        st_q            <= st_d;
        block_state_q   <= block_state_d;
        destroy_pulse_q <= destroy_pulse_d;
        destroy_idx_q   <= destroy_idx_d;
        alive_count_q   <= alive_count_d;
    end

    assign bus.block_state   = block_state_q;
    assign bus.destroy_pulse = destroy_pulse_q;
    assign bus.destroy_idx   = destroy_idx_q;
    assign bus.alive_count   = alive_count_q;
endmodule

// File: tb/tb_destroyable_block_bank.sv
// Directed bench for destroyable_block_bank: one bank with respawn and
// invulnerability, one that never respawns.
module tb_destroyable_block_bank;
    localparam int NB    = 6;
    localparam int CW    = 10;
    localparam int HW    = 2;
    localparam int IW    = 2 * CW + HW;
    localparam int SW    = 2 * CW + 1;

    logic              sim_clk = 1'b0;
    logic              reset;
    logic              frame_tick;
    logic [NB*IW-1:0]  init_state;

    int checks   = 0;
    int failures = 0;

    logic [SW-1:0] exp_home;
    logic [SW-1:0] got;

    destroyable_block_bank_if #(.NUM_BLOCKS(NB), .COORD_W(CW), .HP_W(HW)) bus_a ();
    destroyable_block_bank_if #(.NUM_BLOCKS(NB), .COORD_W(CW), .HP_W(HW)) bus_b ();

    destroyable_block_bank #(
        .NUM_BLOCKS(NB), .COORD_W(CW), .HP_W(HW),
        .INVULN_TICKS(4), .RESPAWN_TICKS(3)
    ) dut (
        .sim_clk    (sim_clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .init_state (init_state),
        .bus        (bus_a)
    );

    destroyable_block_bank #(
        .NUM_BLOCKS(NB), .COORD_W(CW), .HP_W(HW),
        .INVULN_TICKS(4), .RESPAWN_TICKS(0)
    ) dut_ng (
        .sim_clk    (sim_clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .init_state (init_state),
        .bus        (bus_b)
    );

    always #5 sim_clk = ~sim_clk;

    function automatic logic [SW-1:0] blk(input logic [NB*SW-1:0] s, input int i);
        return s[i*SW +: SW];
    endfunction

    task automatic step();
        @(posedge sim_clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [2:0] idx, input logic [HW-1:0] dmg);
        bus_a.col_valid = v;
        bus_a.col_idx   = idx;
        bus_a.col_dmg   = dmg;
    endtask

    task automatic drive_b(input logic v, input logic [2:0] idx, input logic [HW-1:0] dmg);
        bus_b.col_valid = v;
        bus_b.col_idx   = idx;
        bus_b.col_dmg   = dmg;
    endtask

    task automatic test_reset();
        init_state = '0;
        init_state[2*IW +: IW] = {10'd100, 10'd50, 2'd2};
        init_state[0*IW +: IW] = {10'd7, 10'd9, 2'd0};
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NB; i++) begin
            got = blk(bus_a.block_state, i);
            if (got !== ((i == 2) ? exp_home : '0)) begin
                failures++;
                $display("FAIL reset_blk%0d got=%h exp=%h", i, got, (i == 2) ? exp_home : '0);
            end
            checks++;
        end
        if (bus_a.alive_count !== 3'd1) begin
            failures++; $display("FAIL reset_alive got=%0d exp=1", bus_a.alive_count);
        end
        checks++;
        if (bus_a.destroy_pulse !== 1'b0 || bus_a.destroy_idx !== 3'd0) begin
            failures++; $display("FAIL reset_destroy got=%b/%0d exp=0/0", bus_a.destroy_pulse, bus_a.destroy_idx);
        end
        checks++;
        if (bus_b.alive_count !== 3'd1) begin
            failures++; $display("FAIL reset_alive_ng got=%0d exp=1", bus_b.alive_count);
        end
        checks++;
    endtask

    task automatic test_invuln();
        drive_a(1'b1, 3'd2, 2'd1);
        step();
        if (blk(bus_a.block_state, 2) !== exp_home || bus_a.destroy_pulse !== 1'b0) begin
            failures++; $display("FAIL inv_first_hit got=%h/%b exp=%h/0", blk(bus_a.block_state, 2), bus_a.destroy_pulse, exp_home);
        end
        checks++;
        drive_a(1'b0, 3'd0, 2'd0);
        frame_tick = 1'b1;
        repeat (3) step();
        frame_tick = 1'b0;
        drive_a(1'b1, 3'd2, 2'd1);
        step();
        if (blk(bus_a.block_state, 2) !== exp_home || bus_a.destroy_pulse !== 1'b0) begin
            failures++; $display("FAIL inv_hit_ignored got=%h/%b exp=%h/0", blk(bus_a.block_state, 2), bus_a.destroy_pulse, exp_home);
        end
        checks++;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        if (blk(bus_a.block_state, 2) !== exp_home || bus_a.destroy_pulse !== 1'b0) begin
            failures++; $display("FAIL inv_hit_on_last_tick got=%h/%b exp=%h/0", blk(bus_a.block_state, 2), bus_a.destroy_pulse, exp_home);
        end
        checks++;
        step();
        drive_a(1'b0, 3'd0, 2'd0);
        if (bus_a.destroy_pulse !== 1'b1 || bus_a.destroy_idx !== 3'd2 ||
            blk(bus_a.block_state, 2) !== '0 || bus_a.alive_count !== 3'd0) begin
            failures++;
            $display("FAIL inv_lethal pulse=%b idx=%0d blk=%h alive=%0d exp 1/2/0/0",
                     bus_a.destroy_pulse, bus_a.destroy_idx, blk(bus_a.block_state, 2), bus_a.alive_count);
        end
        checks++;
        step();
        if (bus_a.destroy_pulse !== 1'b0) begin
            failures++; $display("FAIL inv_pulse_width got=%b exp=0", bus_a.destroy_pulse);
        end
        checks++;
    endtask

    task automatic test_respawn();
        frame_tick = 1'b1;
        repeat (2) step();
        if (blk(bus_a.block_state, 2) !== '0 || bus_a.alive_count !== 3'd0) begin
            failures++; $display("FAIL respawn_early got=%h/%0d exp=0/0", blk(bus_a.block_state, 2), bus_a.alive_count);
        end
        checks++;
        step();
        frame_tick = 1'b0;
        if (blk(bus_a.block_state, 2) !== exp_home || bus_a.alive_count !== 3'd1) begin
            failures++; $display("FAIL respawn_visible got=%h/%0d exp=%h/1", blk(bus_a.block_state, 2), bus_a.alive_count, exp_home);
        end
        checks++;
        drive_a(1'b1, 3'd2, 2'd1);
        step();
        drive_a(1'b0, 3'd0, 2'd0);
        if (blk(bus_a.block_state, 2) !== exp_home || bus_a.destroy_pulse !== 1'b0) begin
            failures++; $display("FAIL respawn_hp_restored got=%h/%b exp=%h/0", blk(bus_a.block_state, 2), bus_a.destroy_pulse, exp_home);
        end
        checks++;
    endtask

    task automatic test_saturate();
        frame_tick = 1'b1;
        repeat (4) step();
        drive_a(1'b1, 3'd2, 2'd3);
        step();
        frame_tick = 1'b0;
        if (bus_a.destroy_pulse !== 1'b1 || bus_a.destroy_idx !== 3'd2 || blk(bus_a.block_state, 2) !== '0) begin
            failures++; $display("FAIL sat_lethal pulse=%b idx=%0d blk=%h exp 1/2/0",
                                 bus_a.destroy_pulse, bus_a.destroy_idx, blk(bus_a.block_state, 2));
        end
        checks++;
        step();
        drive_a(1'b0, 3'd0, 2'd0);
        if (bus_a.destroy_pulse !== 1'b0 || blk(bus_a.block_state, 2) !== '0) begin
            failures++; $display("FAIL sat_dead_hit pulse=%b blk=%h exp 0/0", bus_a.destroy_pulse, blk(bus_a.block_state, 2));
        end
        checks++;
        frame_tick = 1'b1;
        repeat (2) step();
        if (blk(bus_a.block_state, 2) !== '0) begin
            failures++; $display("FAIL sat_no_tick_on_kill got=%h exp=0", blk(bus_a.block_state, 2));
        end
        checks++;
        step();
        frame_tick = 1'b0;
        if (blk(bus_a.block_state, 2) !== exp_home) begin
            failures++; $display("FAIL sat_respawn got=%h exp=%h", blk(bus_a.block_state, 2), exp_home);
        end
        checks++;
    endtask

    task automatic test_ignored();
        drive_a(1'b1, 3'd6, 2'd3);
        step();
        if (blk(bus_a.block_state, 2) !== exp_home || bus_a.destroy_pulse !== 1'b0 || bus_a.alive_count !== 3'd1) begin
            failures++; $display("FAIL ign_idx6 blk=%h pulse=%b alive=%0d", blk(bus_a.block_state, 2), bus_a.destroy_pulse, bus_a.alive_count);
        end
        checks++;
        drive_a(1'b1, 3'd7, 2'd3);
        step();
        if (blk(bus_a.block_state, 2) !== exp_home || bus_a.destroy_pulse !== 1'b0) begin
            failures++; $display("FAIL ign_idx7 blk=%h pulse=%b", blk(bus_a.block_state, 2), bus_a.destroy_pulse);
        end
        checks++;
        drive_a(1'b1, 3'd2, 2'd0);
        step();
        if (blk(bus_a.block_state, 2) !== exp_home || bus_a.destroy_pulse !== 1'b0) begin
            failures++; $display("FAIL ign_dmg0 blk=%h pulse=%b", blk(bus_a.block_state, 2), bus_a.destroy_pulse);
        end
        checks++;
        // Block must still be ALIVE with full hp, so dmg=2 is lethal now
        drive_a(1'b1, 3'd2, 2'd2);
        step();
        drive_a(1'b0, 3'd0, 2'd0);
        if (bus_a.destroy_pulse !== 1'b1 || blk(bus_a.block_state, 2) !== '0) begin
            failures++; $display("FAIL ign_then_lethal pulse=%b blk=%h exp 1/0", bus_a.destroy_pulse, blk(bus_a.block_state, 2));
        end
        checks++;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        reset = 1'b1;
        drive_a(1'b1, 3'd2, 2'd3);
        step();
        reset = 1'b0;
        drive_a(1'b0, 3'd0, 2'd0);
        if (bus_a.destroy_pulse !== 1'b0 || blk(bus_a.block_state, 2) !== exp_home || bus_a.alive_count !== 3'd1) begin
            failures++; $display("FAIL reset_mid_dead pulse=%b blk=%h alive=%0d exp 0/%h/1",
                                 bus_a.destroy_pulse, blk(bus_a.block_state, 2), bus_a.alive_count, exp_home);
        end
        checks++;
        step();
        if (blk(bus_a.block_state, 2) !== exp_home || bus_a.destroy_pulse !== 1'b0) begin
            failures++; $display("FAIL after_reset_hold blk=%h pulse=%b", blk(bus_a.block_state, 2), bus_a.destroy_pulse);
        end
        checks++;
    endtask

    task automatic test_never_respawn();
        drive_b(1'b1, 3'd2, 2'd2);
        step();
        drive_b(1'b0, 3'd0, 2'd0);
        if (bus_b.destroy_pulse !== 1'b1 || bus_b.destroy_idx !== 3'd2 || bus_b.alive_count !== 3'd0) begin
            failures++; $display("FAIL ng_lethal pulse=%b idx=%0d alive=%0d exp 1/2/0",
                                 bus_b.destroy_pulse, bus_b.destroy_idx, bus_b.alive_count);
        end
        checks++;
        frame_tick = 1'b1;
        repeat (1000) step();
        frame_tick = 1'b0;
        if (blk(bus_b.block_state, 2) !== '0 || bus_b.alive_count !== 3'd0) begin
            failures++; $display("FAIL ng_stays_gone blk=%h alive=%0d exp 0/0", blk(bus_b.block_state, 2), bus_b.alive_count);
        end
        checks++;
        drive_b(1'b1, 3'd2, 2'd1);
        step();
        drive_b(1'b0, 3'd0, 2'd0);
        if (bus_b.destroy_pulse !== 1'b0) begin
            failures++; $display("FAIL ng_gone_hit pulse=%b exp=0", bus_b.destroy_pulse);
        end
        checks++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        if (blk(bus_b.block_state, 2) !== exp_home || bus_b.alive_count !== 3'd1) begin
            failures++; $display("FAIL ng_reset_restore blk=%h alive=%0d exp %h/1", blk(bus_b.block_state, 2), bus_b.alive_count, exp_home);
        end
        checks++;
    endtask

    initial begin
        exp_home   = {10'd100, 10'd50, 1'b1};
        reset      = 1'b0;
        frame_tick = 1'b0;
        init_state = '0;
        drive_a(1'b0, 3'd0, 2'd0);
        drive_b(1'b0, 3'd0, 2'd0);
        step();
        test_reset();
        test_invuln();
        test_respawn();
        test_saturate();
        test_ignored();
        test_never_respawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/destroyable_block_bank.md
# destroyable_block_bank

Parametrised bank of NUM_BLOCKS destroyable blocks with per-block hit points, post-hit invulnerability and timed respawn. It sits between the collision detector and the renderer. It takes at most one collision report per cycle and publishes the packed {x, y, visible} state of every block. It also emits a one-cycle event when a block is destroyed, for scoring and sound.

## Interface
Parameters:
- NUM_BLOCKS, 8: number of blocks in the bank (1..64).
- COORD_W, 10: width of the X and Y coordinates.
- HP_W, 2: width of the hit-point field.
- INVULN_TICKS, 4: frame ticks a block ignores hits after a non-lethal hit. 0 disables invulnerability.
- RESPAWN_TICKS, 120: frame ticks from destruction to respawn. 0 means the block never respawns.

Ports:
- sim_clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; reloads every block from init_state.
- frame_tick  in  1  one-cycle pulse per video frame; advances the invulnerability and respawn timers.
- init_state  in  NUM_BLOCKS*(2*COORD_W+HP_W)  per block {x, y, hp}; block 0 occupies the LSBs. Sampled only while reset=1.
- col_valid  in  1  a collision report is present this cycle.
- col_idx  in  $clog2(NUM_BLOCKS)  index of the block that was hit.
- col_dmg  in  HP_W  damage carried by the report; 0 is a no-op.
- block_state  out  NUM_BLOCKS*(2*COORD_W+1)  per block {x, y, visible}; block 0 occupies the LSBs.
- destroy_pulse  out  1  high for one cycle when a block reaches 0 HP.
- destroy_idx  out  $clog2(NUM_BLOCKS)  index of the destroyed block; valid while destroy_pulse=1.
- alive_count  out  $clog2(NUM_BLOCKS+1)  number of blocks currently visible.

## Operation
Each block holds the following:
- Stored home coordinates and initial HP, latched at reset.
- Current HP.
- A timer of width $clog2(max(INVULN_TICKS, RESPAWN_TICKS)+1).
- A 2-bit state.

Block states:
- ALIVE: visible=1. A hit with col_dmg>0 computes hp − col_dmg, saturating at 0.
  - Result 0: go to DEAD, or GONE if RESPAWN_TICKS=0, and raise destroy_pulse.
  - Result non-zero: go to INVULN with timer=INVULN_TICKS, or stay ALIVE if INVULN_TICKS=0.
- INVULN: visible=1. Hits are ignored. Each frame_tick decrements the timer; on the tick that makes it 0, return to ALIVE.
- DEAD: visible=0 and block_state x/y read 0, while the home coordinates are retained. Each frame_tick decrements the timer; on the tick that makes it 0, go to ALIVE with hp restored to the initial HP, and output x/y return to the home values.
- GONE: visible=0, x/y read 0. Left only by reset.

Reset:
- A block whose initial HP is 0 resets into GONE.
- Every other block resets into ALIVE with hp equal to its initial HP.

Rules:
- A col_idx ≥ NUM_BLOCKS is ignored.
- col_dmg=0 is ignored and does not start invulnerability.
- A hit on a block in DEAD or GONE is ignored and raises no pulse.
- Hit and frame_tick on the same block in the same cycle: the hit is evaluated against the pre-tick state, and the state transition caused by the hit takes precedence over the tick.
  - Example: INVULN with timer=1 ticks to ALIVE, and the hit in that same cycle is ignored.
  - Example: a lethal hit loads the DEAD timer to RESPAWN_TICKS and does not decrement it that cycle.
- Timers of blocks not targeted by the report advance normally in that cycle.
- alive_count counts the visible blocks as registered, in the same cycle as block_state.

## Timing
- All outputs are registered. A col_valid sampled at edge N is reflected in block_state, destroy_pulse and alive_count after edge N.
- Respawn: a block is destroyed at edge N. It is visible again after the RESPAWN_TICKS-th frame_tick that follows edge N.
- Reset takes priority over all inputs, including in the middle of a respawn or invulnerability period. During reset, destroy_pulse=0.
- Output values after the reset edge:
  - block_state equals the init coordinates with visible=(hp≠0); GONE blocks read x=y=0.
  - destroy_pulse=0 and destroy_idx=0.
  - alive_count equals the number of blocks with non-zero initial HP.
- Throughput: one collision report per cycle, no backpressure.

## Test plan
- Reset with block 2 = {x=100, y=50, hp=2}, all other blocks hp=0. Expected on the next cycle: block 2 reads {100, 50, 1}, all other blocks read {0, 0, 0}, alive_count=1.
- Block 2 ALIVE with hp=2, INVULN_TICKS=4. Send col_idx=2, dmg=1: block stays visible. Send another hit within the next 4 frame ticks: ignored. After the 4th tick, a dmg=1 hit gives destroy_pulse=1, destroy_idx=2, block_state {0, 0, 0}, alive_count=0.
- Block 2 destroyed with RESPAWN_TICKS=3. Expected: still invisible after 2 frame ticks; after the 3rd tick it reads {100, 50, 1} with hp=2.
- RESPAWN_TICKS=0 and a lethal hit. Expected: the block stays invisible after 1000 frame ticks and returns only after reset.
- Hit with col_dmg=3 on a block with hp=1: hp saturates at 0, one destroy_pulse. A further hit in the next cycle: no pulse.
- Out-of-range col_idx, col_dmg=0, and reset asserted in the middle of DEAD: no state change for the first two; reset restores all blocks with no destroy_pulse.
